// File: rtl/io_timer.sv
// rtl/io_timer.sv - memory-mapped 16-bit timer with prescaler, compare match and atomic byte access
// Overflow flag/interrupt (STAT.OF, CTRL.OIE) exist only when IO_TIMER_OVERFLOW_IRQ_EN is defined.
module io_timer #(
  parameter logic [15:0] BASE_ADDR = 16'h1010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dMemIOAddress,
  input  logic [7:0]  dMemIOIn,
  output logic [7:0]  dMemIOOut,
  input  logic        dMemIOWriteEn,
  input  logic        dMemIOReadEn,
  output logic        interrupt,
  input  logic        interrupt_clr
);

  localparam logic [2:0] OFF_CTRL  = 3'd0;
  localparam logic [2:0] OFF_CNT_L = 3'd1;
  localparam logic [2:0] OFF_CNT_H = 3'd2;
  localparam logic [2:0] OFF_CMP_L = 3'd3;
  localparam logic [2:0] OFF_CMP_H = 3'd4;
  localparam logic [2:0] OFF_STAT  = 3'd5;

`ifdef IO_TIMER_OVERFLOW_IRQ_EN
  localparam logic [5:0] CTRL_MASK = 6'h3F;
`else
  localparam logic [5:0] CTRL_MASK = 6'h37;
`endif

  logic [15:0] offset;
  logic        hit;
  logic [2:0]  reg_sel;
  logic        wr;
  logic        rd;
  logic        wr_ctrl;
  logic        wr_cnt_l;
  logic        wr_cnt_h;
  logic        wr_cmp_l;
  logic        wr_cmp_h;
  logic        wr_stat;

  logic [5:0]  ctrl;
  logic [15:0] cnt;
  logic [15:0] cmp;
  logic [7:0]  cnt_tmp;
  logic [7:0]  cmp_tmp;
  logic [7:0]  shadow;
  logic [7:0]  presc;
  logic [7:0]  presc_limit;
  logic        mf;
  logic        of_bit;
  logic        of_irq;
  logic        tick;
  logic        match;
  logic        mf_clr;
  logic [7:0]  rd_data;

  // Offset wraps below BASE_ADDR to a large value, so one compare covers both ends.
  assign offset   = dMemIOAddress - BASE_ADDR;
  assign hit      = (offset < 16'd6);
  assign reg_sel  = offset[2:0];
  assign wr       = dMemIOWriteEn & hit;
  assign rd       = dMemIOReadEn & hit;
  assign wr_ctrl  = wr & (reg_sel == OFF_CTRL);
  assign wr_cnt_l = wr & (reg_sel == OFF_CNT_L);
  assign wr_cnt_h = wr & (reg_sel == OFF_CNT_H);
  assign wr_cmp_l = wr & (reg_sel == OFF_CMP_L);
  assign wr_cmp_h = wr & (reg_sel == OFF_CMP_H);
  assign wr_stat  = wr & (reg_sel == OFF_STAT);

  always_comb begin
    presc_limit = 8'd0;
    case (ctrl[5:4])
      2'd0: presc_limit = 8'd0;
      2'd1: presc_limit = 8'd7;
      2'd2: presc_limit = 8'd63;
      default: presc_limit = 8'd255;
    endcase
  end

  assign tick   = ctrl[0] & (presc == presc_limit);
  assign match  = (cnt == cmp);
  assign mf_clr = interrupt_clr | (wr_stat & dMemIOIn[0]);

`ifdef IO_TIMER_OVERFLOW_IRQ_EN
  logic of_flag;
  logic wrap;

  assign wrap = tick & ~(match & ctrl[2]) & (cnt == 16'hFFFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      of_flag <= 1'b0;
    end else if (wrap) begin
      of_flag <= 1'b1;
    end else if (interrupt_clr | (wr_stat & dMemIOIn[1])) begin
      of_flag <= 1'b0;
    end
  end

  assign of_bit = of_flag;
  assign of_irq = of_flag & ctrl[3];
`else
  assign of_bit = 1'b0;
  assign of_irq = 1'b0;
`endif

  always_comb begin
    rd_data = 8'h00;
    case (reg_sel)
      OFF_CTRL:  rd_data = {2'b00, ctrl};
      OFF_CNT_L: rd_data = cnt[7:0];
      OFF_CNT_H: rd_data = shadow;
      OFF_CMP_L: rd_data = cmp[7:0];
      OFF_CMP_H: rd_data = cmp[15:8];
      OFF_STAT:  rd_data = {6'b000000, of_bit, mf};
      default:   rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl      <= 6'd0;
      cnt       <= 16'd0;
      cmp       <= 16'd0;
      cnt_tmp   <= 8'd0;
      cmp_tmp   <= 8'd0;
      shadow    <= 8'd0;
      presc     <= 8'd0;
      mf        <= 1'b0;
      dMemIOOut <= 8'h00;
      interrupt <= 1'b0;
    end else begin
      if (wr_ctrl)  ctrl    <= dMemIOIn[5:0] & CTRL_MASK;
      if (wr_cnt_l) cnt_tmp <= dMemIOIn;
      if (wr_cmp_l) cmp_tmp <= dMemIOIn;
      if (wr_cmp_h) cmp     <= {dMemIOIn, cmp_tmp};

      // A CPU commit to CNT overrides the tick in the same cycle.
      if (wr_cnt_h) begin
        cnt <= {dMemIOIn, cnt_tmp};
      end else if (tick) begin
        cnt <= (match & ctrl[2]) ? 16'd0 : cnt + 16'd1;
      end

      if (rd && (reg_sel == OFF_CNT_L)) shadow <= cnt[15:8];

      if (wr_ctrl || !ctrl[0] || tick) begin
        presc <= 8'd0;
      end else begin
        presc <= presc + 8'd1;
      end

      if (tick && match) begin
        mf <= 1'b1;
      end else if (mf_clr) begin
        mf <= 1'b0;
      end

      dMemIOOut <= rd ? rd_data : 8'h00;
      interrupt <= (mf & ctrl[1]) | of_irq;
    end
  end

endmodule

// File: tb/tb_io_timer.sv
// tb/tb_io_timer.sv - scoreboard bench for io_timer: reads queue expected bytes, a monitor pops them
// Expectations for the overflow feature follow IO_TIMER_OVERFLOW_IRQ_EN.
module tb_io_timer;

  localparam logic [15:0] B = 16'h1010;

`ifdef IO_TIMER_OVERFLOW_IRQ_EN
  localparam logic [7:0] OF_STAT  = 8'h02;
  localparam logic       OF_INT   = 1'b1;
  localparam logic [7:0] CTRL_19  = 8'h19;
`else
  localparam logic [7:0] OF_STAT  = 8'h00;
  localparam logic       OF_INT   = 1'b0;
  localparam logic [7:0] CTRL_19  = 8'h11;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dMemIOAddress;
  logic [7:0]  dMemIOIn;
  logic [7:0]  dMemIOOut;
  logic        dMemIOWriteEn;
  logic        dMemIOReadEn;
  logic        interrupt;
  logic        interrupt_clr;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  string       name_q[$];
  logic        rd_d = 1'b0;
  logic        mon_en = 1'b0;
  logic [7:0]  mon_e;
  string       mon_n;

  always #5 clk = ~clk;

  io_timer #(.BASE_ADDR(B)) dut (
    .clk(clk),
    .rst(rst),
    .dMemIOAddress(dMemIOAddress),
    .dMemIOIn(dMemIOIn),
    .dMemIOOut(dMemIOOut),
    .dMemIOWriteEn(dMemIOWriteEn),
    .dMemIOReadEn(dMemIOReadEn),
    .interrupt(interrupt),
    .interrupt_clr(interrupt_clr)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] d);
    dMemIOAddress = addr;
    dMemIOIn      = d;
    dMemIOWriteEn = 1'b1;
    cyc();
    dMemIOWriteEn = 1'b0;
  endtask

  task automatic rd(input logic [15:0] addr, input logic [7:0] exp, input string name);
    dMemIOAddress = addr;
    dMemIOReadEn  = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    cyc();
    dMemIOReadEn = 1'b0;
  endtask

  // Monitor: a read sampled on the last edge must show its queued byte; otherwise the bus is 0.
  always @(posedge clk) rd_d <= dMemIOReadEn;

  always @(negedge clk) begin
    if (rd_d) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %h expected no read", dMemIOOut);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        chk(mon_n, {8'h00, dMemIOOut}, {8'h00, mon_e});
      end
    end else if (mon_en) begin
      chk("idle_out_zero", {8'h00, dMemIOOut}, 16'h0000);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst = 1'b1;
    dMemIOAddress = 16'h0000;
    dMemIOIn = 8'h00;
    dMemIOWriteEn = 1'b0;
    dMemIOReadEn = 1'b0;
    interrupt_clr = 1'b0;
    repeat (2) cyc();
    chk("reset_interrupt", {15'd0, interrupt}, 16'h0000);
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset values and address map
    for (int i = 0; i < 6; i++) rd(B + 16'(i), 8'h00, $sformatf("reset_reg%0d", i));
    rd(B + 16'd6, 8'h00, "read_past_end");
    rd(B - 16'd1, 8'h00, "read_below_base");
    wr(B + 16'd6, 8'hFF);
    rd(B, 8'h00, "ctrl_after_miss_write");

    // Match with auto-reload, PS=0
    wr(B + 16'd3, 8'h03);
    wr(B + 16'd4, 8'h00);
    wr(B, 8'h07);
    rd(B + 16'd1, 8'h00, "ar_cnt0");
    rd(B + 16'd1, 8'h01, "ar_cnt1");
    rd(B + 16'd1, 8'h02, "ar_cnt2");
    rd(B + 16'd1, 8'h03, "ar_cnt3");
    chk("int_before_match", {15'd0, interrupt}, 16'h0000);
    rd(B + 16'd1, 8'h00, "ar_cnt_reload");
    chk("int_after_match", {15'd0, interrupt}, 16'h0001);
    wr(B, 8'h02);
    rd(B + 16'd5, 8'h01, "stat_mf_set");

    // Clear via interrupt_clr
    interrupt_clr = 1'b1;
    cyc();
    interrupt_clr = 1'b0;
    rd(B + 16'd5, 8'h00, "stat_after_clr");
    chk("int_after_clr", {15'd0, interrupt}, 16'h0000);

    // Re-match, then clear via STAT write-1
    wr(B + 16'd1, 8'h03);
    wr(B + 16'd2, 8'h00);
    wr(B, 8'h07);
    wr(B, 8'h02);
    cyc();
    chk("int_rematch", {15'd0, interrupt}, 16'h0001);
    wr(B + 16'd5, 8'h01);
    rd(B + 16'd5, 8'h00, "stat_after_w1c");
    chk("int_after_w1c", {15'd0, interrupt}, 16'h0000);

    // Set wins over interrupt_clr in the same cycle
    wr(B + 16'd1, 8'h03);
    wr(B + 16'd2, 8'h00);
    wr(B, 8'h07);
    interrupt_clr = 1'b1;
    wr(B, 8'h02);
    interrupt_clr = 1'b0;
    rd(B + 16'd5, 8'h01, "stat_set_wins");
    interrupt_clr = 1'b1;
    cyc();
    interrupt_clr = 1'b0;

    // Atomic 16-bit counter write
    wr(B + 16'd1, 8'hFE);
    rd(B + 16'd1, 8'h00, "cnt_l_before_commit");
    rd(B + 16'd2, 8'h00, "cnt_h_before_commit");
    wr(B + 16'd2, 8'h12);
    rd(B + 16'd1, 8'hFE, "cnt_l_commit");
    rd(B + 16'd2, 8'h12, "cnt_h_commit");

    // Consistent read pair across a carry while running
    wr(B + 16'd3, 8'hFF);
    wr(B + 16'd4, 8'hFF);
    wr(B + 16'd1, 8'hFF);
    wr(B + 16'd2, 8'h00);
    wr(B, 8'h01);
    rd(B + 16'd1, 8'hFF, "pair_lo");
    rd(B + 16'd2, 8'h00, "pair_hi_shadow");
    wr(B, 8'h00);

    // Overflow with PS=1
    wr(B + 16'd1, 8'hFF);
    wr(B + 16'd2, 8'hFF);
    wr(B + 16'd3, 8'h00);
    wr(B + 16'd4, 8'h00);
    wr(B, 8'h19);
    repeat (8) cyc();
    chk("int_before_of", {15'd0, interrupt}, 16'h0000);
    rd(B + 16'd5, OF_STAT, "stat_overflow");
    chk("int_overflow", {15'd0, interrupt}, {15'd0, OF_INT});
    rd(B + 16'd1, 8'h00, "cnt_l_after_wrap");
    rd(B + 16'd2, 8'h00, "cnt_h_after_wrap");
    rd(B, CTRL_19, "ctrl_oie");
    wr(B, 8'h00);
    wr(B + 16'd5, 8'h03);
    rd(B + 16'd5, 8'h00, "stat_after_w1c_both");

    // CNT commit overrides a coincident tick
    wr(B + 16'd3, 8'hFF);
    wr(B + 16'd4, 8'hFF);
    wr(B, 8'h01);
    wr(B + 16'd1, 8'h34);
    wr(B + 16'd2, 8'h12);
    rd(B + 16'd1, 8'h34, "commit_over_tick_lo");
    rd(B + 16'd2, 8'h12, "commit_over_tick_hi");

    // Reset mid-count with a coincident write and read
    cyc();
    rst = 1'b1;
    dMemIOAddress = B;
    dMemIOIn = 8'h3F;
    dMemIOWriteEn = 1'b1;
    dMemIOReadEn = 1'b1;
    exp_q.push_back(8'h00);
    name_q.push_back("read_under_reset");
    cyc();
    dMemIOWriteEn = 1'b0;
    dMemIOReadEn = 1'b0;
    rst = 1'b0;
    chk("int_after_rst", {15'd0, interrupt}, 16'h0000);
    for (int i = 0; i < 6; i++) rd(B + 16'(i), 8'h00, $sformatf("post_rst_reg%0d", i));

    repeat (3) cyc();
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      cyc();
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
